// File: rtl/scanline_sched_if.sv
// Sync, configuration and per-line output bundle for the scanline dimming scheduler.
// The master drives syncs/config and observes the registered per-line outputs.
interface scanline_sched_if;
    logic        hs_in;
    logic        vs_in;
    logic [2:0]  cfg_level;
    logic [1:0]  cfg_period;
    logic        cfg_alt;
    logic        cfg_fade;
    logic [2:0]  level;
    logic [11:0] line_cnt;
    logic        frame_odd;
    logic        ramping;

    modport master (
        output hs_in, vs_in, cfg_level, cfg_period, cfg_alt, cfg_fade,
        input  level, line_cnt, frame_odd, ramping
    );

    modport slave (
        input  hs_in, vs_in, cfg_level, cfg_period, cfg_alt, cfg_fade,
        output level, line_cnt, frame_odd, ramping
    );
endinterface

// File: rtl/scanline_sched.sv
// Per-line dim-level scheduler: counts lines from sync falling edges, latches config per
// frame and optionally fades the effective level one step per frame toward the target.
module scanline_sched (
    input  logic             clk,
    input  logic             reset_n,
    scanline_sched_if.slave  bus
);

    typedef enum logic [0:0] {StSteady, StRamp} state_e;

    state_e      state_q, state_d;
    logic        hs_q, vs_q;
    logic        hs_fall, vs_fall;
    logic [2:0]  tgt_q, tgt_d, tgt_in;
    logic [1:0]  period_q, period_d;
    logic        alt_q, alt_d;
    logic        fade_q, fade_d;
    logic [2:0]  eff_q, eff_d;
    logic [2:0]  phase_q, phase_d;
    logic [11:0] line_q, line_d;
    logic        odd_q, odd_d;
    logic [2:0]  level_q, level_d;
    logic [2:0]  last_q, last_d;

    always_comb begin
        hs_fall  = hs_q & ~bus.hs_in;
        vs_fall  = vs_q & ~bus.vs_in;
        tgt_in   = (bus.cfg_level > 3'd4) ? 3'd4 : bus.cfg_level;
        // Dimmed phase is period-1, i.e. period code + 1.
        last_q   = {1'b0, period_q} + 3'd1;
        state_d  = state_q;
        tgt_d    = tgt_q;
        period_d = period_q;
        alt_d    = alt_q;
        fade_d   = fade_q;
        eff_d    = eff_q;
        phase_d  = phase_q;
        line_d   = line_q;
        odd_d    = odd_q;
        if (vs_fall) begin
            tgt_d    = tgt_in;
            period_d = bus.cfg_period;
            alt_d    = bus.cfg_alt;
            fade_d   = bus.cfg_fade;
            line_d   = 12'd0;
            odd_d    = ~odd_q;
            phase_d  = (bus.cfg_alt && !odd_q) ? 3'd1 : 3'd0;
            if (!bus.cfg_fade) begin
                eff_d = tgt_in;
            end else if (eff_q < tgt_in) begin
                eff_d = eff_q + 3'd1;
            end else if (eff_q > tgt_in) begin
                eff_d = eff_q - 3'd1;
            end
            state_d = (eff_d != tgt_in) ? StRamp : StSteady;
        end else if (hs_fall) begin
            line_d  = (line_q == 12'hfff) ? line_q : line_q + 12'd1;
            phase_d = (phase_q == last_q) ? 3'd0 : phase_q + 3'd1;
        end
        last_d  = {1'b0, period_d} + 3'd1;
        level_d = (phase_d == last_d) ? eff_d : 3'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StSteady;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            tgt_q    <= 3'd0;
            period_q <= 2'd0;
            alt_q    <= 1'b0;
            fade_q   <= 1'b0;
            eff_q    <= 3'd0;
            phase_q  <= 3'd0;
            line_q   <= 12'd0;
            odd_q    <= 1'b0;
            level_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            hs_q     <= bus.hs_in;
            vs_q     <= bus.vs_in;
            tgt_q    <= tgt_d;
            period_q <= period_d;
            alt_q    <= alt_d;
            fade_q   <= fade_d;
            eff_q    <= eff_d;
            phase_q  <= phase_d;
            line_q   <= line_d;
            odd_q    <= odd_d;
            level_q  <= level_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.line_cnt  = line_q;
    assign bus.frame_odd = odd_q;
    assign bus.ramping   = (state_q == StRamp);

endmodule

// File: tb/tb_scanline_sched.sv
// Randomized bench for scanline_sched against a per-frame arithmetic model of line dimming.
module tb_scanline_sched;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    scanline_sched_if bus ();

    scanline_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: line index n is unbounded so the dim phase is (start + n) mod period.
    int m_tgt, m_eff, m_per, m_alt, m_fade, m_odd, m_n, m_start, m_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_level();
        int ph;
        ph = (m_start + m_n) % m_per;
        return (ph == m_per - 1) ? m_eff : 0;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_eff = 0; m_per = 2; m_alt = 0; m_fade = 0;
        m_odd = 0; m_n = 0; m_start = 0; m_cnt = 0;
    endtask

    task automatic model_vs();
        int t;
        t = (int'(bus.cfg_level) > 4) ? 4 : int'(bus.cfg_level);
        m_tgt   = t;
        m_per   = int'(bus.cfg_period) + 2;
        m_alt   = int'(bus.cfg_alt);
        m_fade  = int'(bus.cfg_fade);
        m_odd   = 1 - m_odd;
        m_n     = 0;
        m_cnt   = 0;
        m_start = m_alt & m_odd;
        if (m_fade == 0) m_eff = t;
        else if (m_eff < t) m_eff++;
        else if (m_eff > t) m_eff--;
    endtask

    task automatic model_hs();
        m_n++;
        if (m_cnt < 4095) m_cnt++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, int'(bus.level), exp_level());
        check({tag, ".line_cnt"}, int'(bus.line_cnt), m_cnt);
        check({tag, ".frame_odd"}, int'(bus.frame_odd), m_odd);
        check({tag, ".ramping"}, int'(bus.ramping), (m_eff != m_tgt) ? 1 : 0);
    endtask

    task automatic pulse(input bit h, input bit v, input bit chk, input string tag);
        @(posedge clk); #1;
        bus.hs_in = h;
        bus.vs_in = v;
        @(posedge clk); #1;
        bus.hs_in = 1'b0;
        bus.vs_in = 1'b0;
        if (v) model_vs();
        else if (h) model_hs();
        @(posedge clk); #1;
        if (chk) check_all(tag);
    endtask

    task automatic set_cfg(input int l, input int p, input int a, input int f);
        bus.cfg_level  = 3'(l);
        bus.cfg_period = 2'(p);
        bus.cfg_alt    = 1'(a);
        bus.cfg_fade   = 1'(f);
    endtask

    initial begin
        int lv30 [6] = '{2, 0, 2, 0, 2, 0};
        bus.hs_in = 1'b0;
        bus.vs_in = 1'b0;
        set_cfg(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Two-line pattern at level 2.
        set_cfg(2, 0, 0, 0);
        pulse(1'b0, 1'b1, 1'b1, "p30.vs");
        for (int i = 0; i < 6; i++) begin
            pulse(1'b1, 1'b0, 1'b1, "p30.hs");
            check("p30.lvl", int'(bus.level), lv30[i]);
        end
        check("p30.cnt6", int'(bus.line_cnt), 6);

        // Four-line pattern with alternating phase.
        set_cfg(1, 2, 1, 0);
        for (int f = 0; f < 2; f++) begin
            pulse(1'b0, 1'b1, 1'b1, "p31.vs");
            for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 1'b1, "p31.hs");
        end

        // Fade 0 -> 4 over four frames.
        set_cfg(0, 0, 0, 0);
        pulse(1'b0, 1'b1, 1'b1, "p32.clr");
        set_cfg(4, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            pulse(1'b0, 1'b1, 1'b1, "p32.vs");
            pulse(1'b1, 1'b0, 1'b1, "p32.hs");
            check("p32.eff", int'(bus.level), k + 1);
            check("p32.ramp", int'(bus.ramping), (k < 3) ? 1 : 0);
        end

        // Ramp reversal mid-fade.
        set_cfg(0, 0, 0, 0);
        pulse(1'b0, 1'b1, 1'b1, "p33.clr");
        set_cfg(4, 0, 0, 1);
        pulse(1'b0, 1'b1, 1'b1, "p33.up1");
        pulse(1'b0, 1'b1, 1'b1, "p33.up2");
        set_cfg(0, 0, 0, 1);
        pulse(1'b0, 1'b1, 1'b1, "p33.dn1");
        pulse(1'b1, 1'b0, 1'b1, "p33.hs1");
        check("p33.eff1", int'(bus.level), 1);
        check("p33.ramp1", int'(bus.ramping), 1);
        pulse(1'b0, 1'b1, 1'b1, "p33.dn0");
        check("p33.ramp0", int'(bus.ramping), 0);

        // Coincident edges, then line counter saturation.
        set_cfg(3, 1, 1, 0);
        pulse(1'b1, 1'b0, 1'b1, "p34.pre");
        pulse(1'b1, 1'b1, 1'b1, "p34.both");
        check("p34.cnt0", int'(bus.line_cnt), 0);
        for (int i = 0; i < 5000; i++) pulse(1'b1, 1'b0, 1'b0, "p34.sat");
        check_all("p34.end");
        check("p34.cnt_sat", int'(bus.line_cnt), 4095);

        // Random syncs and mid-frame config churn.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 9) < 3) begin
                set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            end
            if (r < 72) pulse(1'b1, 1'b0, 1'b1, "rnd.hs");
            else if (r < 95) pulse(1'b0, 1'b1, 1'b1, "rnd.vs");
            else pulse(1'b1, 1'b1, 1'b1, "rnd.both");
        end

        // Reset mid-frame with eff=3.
        set_cfg(3, 0, 0, 0);
        pulse(1'b0, 1'b1, 1'b1, "p35.vs");
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b1, "p35.hs");
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        check("p35.level", int'(bus.level), 0);
        check("p35.cnt", int'(bus.line_cnt), 0);
        check("p35.odd", int'(bus.frame_odd), 0);
        check("p35.ramp", int'(bus.ramping), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 1'b1, "p35.post");
            check("p35.dark", int'(bus.level), 0);
        end
        pulse(1'b0, 1'b1, 1'b1, "p35.vs2");
        pulse(1'b1, 1'b0, 1'b1, "p35.hs2");
        check("p35.eff", int'(bus.level), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
